// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, state encoding and issue-filter helpers for alu_ctrl_seq.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_NOP        = 4'b0000;
    localparam logic [3:0] OP_MULADD     = 4'b0001;
    localparam logic [3:0] OP_ANDAND     = 4'b1100;
    localparam logic [3:0] OP_LAST_VALID = OP_ANDAND;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Opcodes above OP_LAST_VALID are reserved and leave the ALU idle.
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_MULADD) && (op <= OP_LAST_VALID);
    endfunction

    function automatic logic [3:0] op_filter(input logic [3:0] op);
        return (op <= OP_LAST_VALID) ? op : OP_NOP;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_wb_delay_line.sv
// wb_delay_line: tracks {valid, wb_addr} through the fixed ALU pipeline latency.
module wb_delay_line #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 5
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              push_valid,
    input  logic [AWIDTH-1:0] push_addr,
    output logic              out_valid,
    output logic [AWIDTH-1:0] out_addr,
    output logic              empty
);

    logic [DEPTH-1:0]  vld_q;
    logic [AWIDTH-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]  behind_out;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= push_valid;
            addr_q[0] <= push_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // Empty means nothing is left behind the entry currently presented at the output.
    always_comb begin
        behind_out            = vld_q;
        behind_out[DEPTH-1]   = 1'b0;
        empty                 = !push_valid && (behind_out == '0);
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU issue sequencer: fetches instructions 0..Last_Addr, issues one opcode per unstalled cycle
// and schedules write-backs. Optional perf counters are enabled with ALU_CTRL_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for Start
// FETCH | first read of address 0
// RUN   | issuing, one instruction per unstalled cycle
// DRAIN | last instruction issued, ALU pipeline emptying
// DONE  | one-cycle completion pulse
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int IADDR_WIDTH  = 8,
    parameter int WBADDR_WIDTH = 5,
    parameter int ALU_LATENCY  = 4
) (
    input  logic                      Clk,
    input  logic                      Resetn,
    input  logic                      Start,
    input  logic [IADDR_WIDTH-1:0]    Last_Addr,
    input  logic                      Stall,
    output logic                      Inst_Rd_En,
    output logic [IADDR_WIDTH-1:0]    Inst_Addr,
    input  logic [4+WBADDR_WIDTH-1:0] Inst_Data,
    output logic [3:0]                Opcode,
    output logic                      WB_En,
    output logic [WBADDR_WIDTH-1:0]   WB_Addr,
    output logic                      Busy,
    output logic                      Done
`ifdef ALU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]               Run_Cycles,
    output logic [31:0]               Stall_Cycles
`endif
);

    localparam int IW = 4 + WBADDR_WIDTH;

    state_t                  state, state_nx;
    logic [IADDR_WIDTH-1:0]  last_addr_q, fetch_addr_q;
    logic                    fetch_done_q, data_valid_q, data_last_q;
    logic                    hold_valid_q, hold_last_q;
    logic [IW-1:0]           hold_data_q;
    logic                    iss_valid_q;
    logic [WBADDR_WIDTH-1:0] iss_addr_q;
    logic                    rd_en, rd_last, src_valid, src_last, issue, dl_empty;
    logic [IW-1:0]           src_data;

    always_comb begin
        rd_en     = (state == FETCH) || ((state == RUN) && !Stall && !fetch_done_q);
        Inst_Addr = (state == RUN) ? fetch_addr_q : '0;
        rd_last   = (Inst_Addr == last_addr_q);
        // A held instruction always takes priority; it cannot coexist with fresh read data.
        src_valid = hold_valid_q || data_valid_q;
        src_data  = hold_valid_q ? hold_data_q : Inst_Data;
        src_last  = hold_valid_q ? hold_last_q : data_last_q;
        issue     = (state == RUN) && !Stall && src_valid;

        state_nx = state;
        case (state)
            IDLE:    if (Start) state_nx = FETCH;
            FETCH:   state_nx = RUN;
            RUN:     if (issue && src_last) state_nx = DRAIN;
            DRAIN:   if (dl_empty) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Inst_Rd_En = rd_en;
    assign Busy       = (state != IDLE);
    assign Done       = (state == DONE);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            last_addr_q  <= '0;
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            hold_data_q  <= '0;
            Opcode       <= OP_NOP;
            iss_valid_q  <= 1'b0;
            iss_addr_q   <= '0;
        end else begin
            if ((state == IDLE) && Start) last_addr_q <= Last_Addr;
            if (rd_en) begin
                fetch_addr_q <= Inst_Addr + IADDR_WIDTH'(1);
                fetch_done_q <= rd_last;
            end
            data_valid_q <= rd_en;
            data_last_q  <= rd_en && rd_last;

            if ((state == RUN) && Stall && data_valid_q && !hold_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_last_q  <= data_last_q;
                hold_data_q  <= Inst_Data;
            end else if (issue) begin
                hold_valid_q <= 1'b0;
            end

            Opcode      <= issue ? op_filter(src_data[3:0]) : OP_NOP;
            iss_valid_q <= issue && op_writes(src_data[3:0]);
            iss_addr_q  <= (issue && op_writes(src_data[3:0])) ? src_data[IW-1:4] : '0;
        end
    end

    wb_delay_line #(
        .DEPTH  (ALU_LATENCY),
        .AWIDTH (WBADDR_WIDTH)
    ) u_wb_delay_line (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .push_valid (iss_valid_q),
        .push_addr  (iss_addr_q),
        .out_valid  (WB_En),
        .out_addr   (WB_Addr),
        .empty      (dl_empty)
    );

`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] run_cnt_q, stall_cnt_q;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if ((state == IDLE) && Start) begin
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state != IDLE) && (run_cnt_q != 32'hFFFF_FFFF)) run_cnt_q <= run_cnt_q + 32'd1;
            if ((state == RUN) && Stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign Run_Cycles   = run_cnt_q;
    assign Stall_Cycles = stall_cnt_q;
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq (ALU_LATENCY=4): directed vector table plus reset-abort sequence.
module tb_alu_ctrl_seq;

    localparam int NCYC = 20;

    logic       Clk, Resetn, Start, Stall;
    logic [7:0] Last_Addr;
    logic       Inst_Rd_En;
    logic [7:0] Inst_Addr;
    logic [8:0] Inst_Data;
    logic [3:0] Opcode;
    logic       WB_En;
    logic [4:0] WB_Addr;
    logic       Busy, Done;
`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] Run_Cycles, Stall_Cycles;
`endif

    alu_ctrl_seq #(.IADDR_WIDTH(8), .WBADDR_WIDTH(5), .ALU_LATENCY(4)) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .Start      (Start),
        .Last_Addr  (Last_Addr),
        .Stall      (Stall),
        .Inst_Rd_En (Inst_Rd_En),
        .Inst_Addr  (Inst_Addr),
        .Inst_Data  (Inst_Data),
        .Opcode     (Opcode),
        .WB_En      (WB_En),
        .WB_Addr    (WB_Addr),
        .Busy       (Busy),
        .Done       (Done)
`ifdef ALU_CTRL_PERF_CNT_EN
        ,
        .Run_Cycles   (Run_Cycles),
        .Stall_Cycles (Stall_Cycles)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [8:0] mem [256];
    initial Inst_Data = '0;
    always @(posedge Clk) if (Inst_Rd_En) Inst_Data <= mem[Inst_Addr];

    typedef struct {
        string            name;
        logic [7:0]       last;
        int               stall_a;
        int               stall_n;
        int               xstart;
        int               done_cyc;
        logic [3:0][8:0]  prog;
        logic [3:0][15:0] ev_op;
        logic [3:0][15:0] ev_wb;
    } vec_t;

    vec_t vecs[5];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [8:0] pi(int wb, int op);
        return {wb[4:0], op[3:0]};
    endfunction

    function automatic logic [15:0] ev(int cyc, int val);
        return {cyc[7:0], val[7:0]};
    endfunction

    function automatic vec_t mk(string nm, int last, int sa, int sn, int xs, int dc,
                                logic [3:0][8:0] prog, logic [3:0][15:0] eo, logic [3:0][15:0] ew);
        vec_t v;
        v.name = nm; v.last = last[7:0]; v.stall_a = sa; v.stall_n = sn; v.xstart = xs;
        v.done_cyc = dc; v.prog = prog; v.ev_op = eo; v.ev_wb = ew;
        return v;
    endfunction

    task automatic chk(string nm, int cyc, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic load_prog(logic [3:0][8:0] prog);
        for (int i = 0; i < 8; i++) mem[i] = (i < 4) ? prog[i] : 9'h1FF;
    endtask

    task automatic run_vec(int v);
        logic [11:0] tr [NCYC];
        logic [11:0] e;
        int          rd_cnt, max_addr;
        rd_cnt = 0; max_addr = 0;
        load_prog(vecs[v].prog);
        for (int c = 0; c < NCYC; c++) begin
            Start     = (c == 0) || (c == vecs[v].xstart);
            Stall     = (c >= vecs[v].stall_a) && (c < vecs[v].stall_a + vecs[v].stall_n);
            Last_Addr = vecs[v].last;
            #2;
            if (Inst_Rd_En) begin
                rd_cnt++;
                if (int'(Inst_Addr) > max_addr) max_addr = int'(Inst_Addr);
            end
            tr[c] = {Busy, Done, WB_En, WB_Addr, Opcode};
            @(posedge Clk); #1;
        end
        Start = 1'b0; Stall = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            e = '0;
            e[11] = (c >= 1) && (c <= vecs[v].done_cyc);
            e[10] = (c == vecs[v].done_cyc);
            for (int k = 0; k < 4; k++) begin
                if (vecs[v].ev_op[k][15:8] == 8'(c) && c != 0) e[3:0] = vecs[v].ev_op[k][3:0];
                if (vecs[v].ev_wb[k][15:8] == 8'(c) && c != 0) e[9:4] = {1'b1, vecs[v].ev_wb[k][4:0]};
            end
            chk({vecs[v].name, "_outs"}, c, 32'(tr[c]), 32'(e));
        end
        chk({vecs[v].name, "_reads"}, -1, rd_cnt, int'(vecs[v].last) + 1);
        chk({vecs[v].name, "_max_rd_addr"}, -1, max_addr, int'(vecs[v].last));
`ifdef ALU_CTRL_PERF_CNT_EN
        chk({vecs[v].name, "_run_cycles"}, -1, Run_Cycles, vecs[v].done_cyc);
        chk({vecs[v].name, "_stall_cycles"}, -1, Stall_Cycles, vecs[v].stall_n);
`endif
    endtask

    initial begin
        logic [3:0][8:0] basic, single;
        int              seen;
        Resetn = 1'b0; Start = 1'b0; Stall = 1'b0; Last_Addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        basic  = {pi(4, 12), pi(3, 4), pi(2, 3), pi(1, 1)};
        single = {pi(31, 15), pi(31, 15), pi(31, 15), pi(9, 5)};
        vecs[0] = mk("basic", 3, -1, 0, -1, 11, basic,
                     {ev(6, 12), ev(5, 4), ev(4, 3), ev(3, 1)},
                     {ev(10, 4), ev(9, 3), ev(8, 2), ev(7, 1)});
        vecs[1] = mk("nop_rsvd", 3, -1, 0, -1, 11, {pi(8, 3), pi(7, 14), pi(6, 0), pi(5, 3)},
                     {ev(6, 3), ev(3, 3), 16'h0, 16'h0},
                     {ev(10, 8), ev(7, 5), 16'h0, 16'h0});
        vecs[2] = mk("stall", 3, 3, 2, -1, 13, basic,
                     {ev(8, 12), ev(7, 4), ev(6, 3), ev(3, 1)},
                     {ev(12, 4), ev(11, 3), ev(10, 2), ev(7, 1)});
        vecs[3] = mk("single", 0, -1, 0, 8, 8, single,
                     {ev(3, 5), 16'h0, 16'h0, 16'h0},
                     {ev(7, 9), 16'h0, 16'h0, 16'h0});
        vecs[4] = mk("single_rerun", 0, -1, 0, 4, 8, single,
                     {ev(3, 5), 16'h0, 16'h0, 16'h0},
                     {ev(7, 9), 16'h0, 16'h0, 16'h0});

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outs", -1, 32'({Inst_Rd_En, Inst_Addr, Opcode, WB_En, WB_Addr, Busy, Done}), 32'd0);
        Resetn = 1'b1;
        @(posedge Clk); #1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Abort a run with reset while instruction 1 is on Opcode.
        load_prog(basic);
        Last_Addr = 8'd3; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        chk("abort_pre_busy", 4, 32'(Busy), 32'd1);
        chk("abort_pre_opcode", 4, 32'(Opcode), 32'd3);
        Resetn = 1'b0;
        #1;
        chk("abort_outs", 4, 32'({Inst_Rd_En, Inst_Addr, Opcode, WB_En, WB_Addr, Busy, Done}), 32'd0);
        seen = 0;
        repeat (2) begin @(posedge Clk); #1; if (Done || Busy || WB_En) seen++; end
        Resetn = 1'b1;
        repeat (14) begin @(posedge Clk); #1; if (Done || Busy || WB_En) seen++; end
        chk("abort_no_done", -1, seen, 0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
